// File: rtl/bcd_time_display_scanner.sv
// Six-digit multiplexed 7-segment scanner for an HH:MM:SS BCD clock.
// The time is latched once per scan frame so a rollover never tears a frame.
module bcd_time_display_scanner #(
   parameter int SCAN_DIV   = 1000,
   parameter bit BLANK_LZ   = 1'b1,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic [3:0] sec_units,
   input  logic [3:0] sec_tens,
   input  logic [3:0] min_units,
   input  logic [3:0] min_tens,
   input  logic [3:0] hour_units,
   input  logic [1:0] hour_tens,
   output logic [6:0] seg,
   output logic       dp,
   output logic [5:0] an,
   output logic       frame_start
);

   localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic          tick;
   logic          wrap;

   logic [3:0] snap_su, snap_st, snap_mu, snap_mt, snap_hu;
   logic [1:0] snap_ht;

   logic [3:0] digit;
   logic [6:0] code;
   logic       blank;
   logic [5:0] an_q;
   logic [6:0] seg_q;
   logic       dp_q;

   assign tick = (cnt == CW'(SCAN_DIV - 1));
   assign wrap = tick && (idx == 3'd5);

   function automatic logic [6:0] decode(input logic [3:0] v);
      case (v)
         4'd0:    decode = 7'h3F;
         4'd1:    decode = 7'h06;
         4'd2:    decode = 7'h5B;
         4'd3:    decode = 7'h4F;
         4'd4:    decode = 7'h66;
         4'd5:    decode = 7'h6D;
         4'd6:    decode = 7'h7D;
         4'd7:    decode = 7'h07;
         4'd8:    decode = 7'h7F;
         4'd9:    decode = 7'h6F;
         default: decode = 7'h40;
      endcase
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt         <= '0;
         idx         <= 3'd0;
         frame_start <= 1'b0;
      end else begin
         cnt         <= tick ? '0 : cnt + 1'b1;
         frame_start <= wrap;
         if (tick) idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      end
   end

   // All six digits are captured together, only at the frame boundary.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         snap_su <= '0;
         snap_st <= '0;
         snap_mu <= '0;
         snap_mt <= '0;
         snap_hu <= '0;
         snap_ht <= '0;
      end else if (wrap) begin
         snap_su <= sec_units;
         snap_st <= sec_tens;
         snap_mu <= min_units;
         snap_mt <= min_tens;
         snap_hu <= hour_units;
         snap_ht <= hour_tens;
      end
   end

   always_comb begin
      digit = 4'd0;
      case (idx)
         3'd0:    digit = snap_su;
         3'd1:    digit = snap_st;
         3'd2:    digit = snap_mu;
         3'd3:    digit = snap_mt;
         3'd4:    digit = snap_hu;
         3'd5:    digit = {2'b00, snap_ht};
         default: digit = 4'd0;
      endcase
      // Hour tens of 3 is out of range even though it decodes as a digit.
      code  = ((idx == 3'd5) && (snap_ht == 2'd3)) ? 7'h40 : decode(digit);
      blank = BLANK_LZ && (idx == 3'd5) && (snap_ht == 2'd0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         an_q  <= '0;
         seg_q <= '0;
         dp_q  <= 1'b0;
      end else if (!en) begin
         an_q  <= '0;
         seg_q <= '0;
         dp_q  <= 1'b0;
      end else begin
         an_q  <= blank ? 6'd0 : (6'd1 << idx);
         seg_q <= blank ? 7'd0 : code;
         dp_q  <= ((idx == 3'd2) || (idx == 3'd4)) && !snap_su[0];
      end
   end

   assign an  = ACTIVE_LOW ? ~an_q  : an_q;
   assign seg = ACTIVE_LOW ? ~seg_q : seg_q;
   assign dp  = ACTIVE_LOW ? ~dp_q  : dp_q;

endmodule

// File: tb/tb_bcd_time_display_scanner.sv
// Directed bench for the scanner at SCAN_DIV=4, active-high pins; a second
// instance with leading-zero blanking disabled shares the same stimulus.
module tb_bcd_time_display_scanner;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic [3:0] sec_units, sec_tens, min_units, min_tens, hour_units;
   logic [1:0] hour_tens;
   logic [6:0] seg, seg_nb;
   logic       dp, dp_nb;
   logic [5:0] an, an_nb;
   logic       frame_start, frame_start_nb;

   int checks   = 0;
   int failures = 0;

   bcd_time_display_scanner #(.SCAN_DIV(4), .BLANK_LZ(1'b1), .ACTIVE_LOW(1'b0)) dut (
      .clk(clk), .reset(reset), .en(en),
      .sec_units(sec_units), .sec_tens(sec_tens), .min_units(min_units),
      .min_tens(min_tens), .hour_units(hour_units), .hour_tens(hour_tens),
      .seg(seg), .dp(dp), .an(an), .frame_start(frame_start)
   );

   bcd_time_display_scanner #(.SCAN_DIV(4), .BLANK_LZ(1'b0), .ACTIVE_LOW(1'b0)) dut_nb (
      .clk(clk), .reset(reset), .en(en),
      .sec_units(sec_units), .sec_tens(sec_tens), .min_units(min_units),
      .min_tens(min_tens), .hour_units(hour_units), .hour_tens(hour_tens),
      .seg(seg_nb), .dp(dp_nb), .an(an_nb), .frame_start(frame_start_nb)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic slot(input string tag, input logic [5:0] e_an, input logic [6:0] e_seg,
                       input logic e_dp);
      chk({tag, "_an"},  32'(an),  32'(e_an));
      chk({tag, "_seg"}, 32'(seg), 32'(e_seg));
      chk({tag, "_dp"},  32'(dp),  32'(e_dp));
   endtask

   task automatic skip(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Returns at the negedge where frame_start is seen; a timeout is a failure.
   task automatic wait_frame(input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (frame_start) begin
            seen = 1'b1;
            break;
         end
      end
      chk({tag, "_frame_timeout"}, 32'(seen), 32'd1);
   endtask

   initial begin
      int first_fs;
      reset = 1'b1; en = 1'b1;
      hour_tens = 2'd1; hour_units = 4'd2; min_tens = 4'd3;
      min_units = 4'd4; sec_tens = 4'd5; sec_units = 4'd6;
      skip(3);
      chk("rst_an", 32'(an), 32'd0);
      chk("rst_seg", 32'(seg), 32'd0);
      chk("rst_fs", 32'(frame_start), 32'd0);
      reset = 1'b0;

      // First frame: zero snapshot, even sec_units so colon lit on 2 and 4.
      skip(2);
      chk("f0_fs", 32'(frame_start), 32'd0);
      slot("f0_d0", 6'h01, 7'h3F, 1'b0);
      skip(4); slot("f0_d1", 6'h02, 7'h3F, 1'b0);
      skip(4); slot("f0_d2", 6'h04, 7'h3F, 1'b1);
      skip(4); slot("f0_d3", 6'h08, 7'h3F, 1'b0);
      skip(4); slot("f0_d4", 6'h10, 7'h3F, 1'b1);
      skip(4); slot("f0_d5_blank", 6'h00, 7'h00, 1'b0);
      chk("f0_d5_nb_an", 32'(an_nb), 32'h20);
      chk("f0_d5_nb_seg", 32'(seg_nb), 32'h3F);

      // Second frame shows 12:34:56; inputs change to :57 mid-frame.
      wait_frame("f1");
      skip(1);
      chk("f1_fs_one_cycle", 32'(frame_start), 32'd0);
      slot("f1_d0", 6'h01, 7'h7D, 1'b0);
      sec_units = 4'd7;
      skip(4); slot("f1_d1", 6'h02, 7'h6D, 1'b0);
      skip(4); slot("f1_d2", 6'h04, 7'h66, 1'b1);
      skip(4); slot("f1_d3", 6'h08, 7'h4F, 1'b0);
      skip(4); slot("f1_d4", 6'h10, 7'h5B, 1'b1);
      skip(4); slot("f1_d5", 6'h20, 7'h06, 1'b0);

      // Third frame picks up :57 (odd seconds, colon dark); arm a bad sec_tens.
      wait_frame("f2");
      skip(1); slot("f2_d0", 6'h01, 7'h07, 1'b0);
      sec_tens = 4'hC;
      skip(8); slot("f2_d2", 6'h04, 7'h66, 1'b0);
      skip(8); slot("f2_d4", 6'h10, 7'h5B, 1'b0);

      // Fourth frame: dash on digit 1, then en dropped for a few cycles.
      wait_frame("f3");
      skip(1); slot("f3_d0", 6'h01, 7'h07, 1'b0);
      skip(4); slot("f3_d1_dash", 6'h02, 7'h40, 1'b0);
      skip(4); slot("f3_d2", 6'h04, 7'h66, 1'b0);
      en = 1'b0;
      skip(1); slot("en_off", 6'h00, 7'h00, 1'b0);
      skip(3); en = 1'b1;
      skip(1); slot("en_resume_d3", 6'h08, 7'h4F, 1'b0);

      // Asynchronous reset at idx 3.
      #1 reset = 1'b1;
      #1;
      chk("arst_an", 32'(an), 32'd0);
      chk("arst_seg", 32'(seg), 32'd0);
      chk("arst_nb_an", 32'(an_nb), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      first_fs = -1;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (k == 2) slot("post_rst_d0", 6'h01, 7'h3F, 1'b0);
         if (frame_start && first_fs < 0) first_fs = k;
      end
      chk("post_rst_first_fs", 32'(first_fs), 32'd24);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
